// File: rtl/rgb_pwm_fader.sv
// ============================================================================
// Module   : rgb_pwm_fader
// Brief    : Multi-channel LED PWM driver with off/static/blink/breathe modes,
//            linear fade engine and a valid/ready configuration write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_pwm_fader #(
    parameter int CHANNELS      = 3,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 16,
    parameter int STEP_PERIODS  = 4,
    parameter int BLINK_PERIODS = 64,
    parameter int CH_BITS       = 2,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_BITS-1:0]  cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_level,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] fading
);

    localparam int PS_W = (PRESCALE > 1)      ? $clog2(PRESCALE)      : 1;
    localparam int SP_W = (STEP_PERIODS > 1)  ? $clog2(STEP_PERIODS)  : 1;
    localparam int BP_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_STATIC  = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
    localparam logic                POL       = (ACTIVE_LOW != 0);

    logic [PS_W-1:0]     presc_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [SP_W-1:0]     step_cnt_q;
    logic [BP_W-1:0]     blink_cnt_q;
    logic                ready_q;
    logic [CHANNELS-1:0] led_q;
    logic [CHANNELS-1:0] fading_q;

    logic                w_tick;
    logic                w_period_end;
    logic                w_step_en;
    logic                w_blink_en;
    logic                w_accept;
    logic [CHANNELS-1:0] w_lit;
    logic [CHANNELS-1:0] w_fading_d;

    assign w_tick       = (presc_q == PS_W'(PRESCALE - 1));
    assign w_period_end = w_tick && (pwm_cnt_q == LEVEL_MAX);
    assign w_step_en    = w_period_end && (step_cnt_q  == SP_W'(STEP_PERIODS - 1));
    assign w_blink_en   = w_period_end && (blink_cnt_q == BP_W'(BLINK_PERIODS - 1));
    assign w_accept     = cfg_valid && ready_q;

    assign cfg_ready = ready_q;
    assign led       = led_q;
    assign fading    = fading_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q     <= '0;
            pwm_cnt_q   <= '0;
            step_cnt_q  <= '0;
            blink_cnt_q <= '0;
            ready_q     <= 1'b0;
            led_q       <= {CHANNELS{POL}};
            fading_q    <= '0;
        end else begin
            presc_q <= w_tick ? '0 : presc_q + 1'b1;
            if (w_tick) begin
                pwm_cnt_q <= pwm_cnt_q + 1'b1;
            end
            if (w_period_end) begin
                step_cnt_q  <= w_step_en  ? '0 : step_cnt_q  + 1'b1;
                blink_cnt_q <= w_blink_en ? '0 : blink_cnt_q + 1'b1;
            end
            // Ready drops for exactly one cycle after each accepted write.
            ready_q  <= ~w_accept;
            led_q    <= w_lit ^ {CHANNELS{POL}};
            fading_q <= w_fading_d;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [1:0]          mode_q,  mode_d;
        logic [PWM_BITS-1:0] level_q, level_d;
        logic [PWM_BITS-1:0] cur_q,   cur_d;
        logic [PWM_BITS-1:0] duty_q,  duty_d;
        logic                down_q,  down_d;
        logic                ph_q,    ph_d;
        logic                fad_d;
        logic                w_wr;
        logic [PWM_BITS:0]   w_cur_up;
        logic [PWM_BITS-1:0] w_cur_dn;
        logic [PWM_BITS-1:0] w_target;
        logic [PWM_BITS-1:0] w_target_d;

        assign w_wr       = w_accept && (cfg_chan == CH_BITS'(gi));
        assign w_cur_up   = {1'b0, cur_q} + 1'b1;
        assign w_cur_dn   = (cur_q == '0) ? '0 : cur_q - 1'b1;
        assign w_target   = (mode_q == MODE_STATIC) ? level_q : '0;
        assign w_target_d = (mode_d == MODE_STATIC) ? level_d : '0;

        always_comb begin
            mode_d  = mode_q;
            level_d = level_q;
            cur_d   = cur_q;
            down_d  = down_q;
            ph_d    = ph_q;
            if (w_wr) begin
                mode_d  = cfg_mode;
                level_d = cfg_level;
                if (cfg_mode == MODE_BREATHE && mode_q != MODE_BREATHE) begin
                    down_d = 1'b0;
                end
                if (cfg_mode == MODE_BLINK && mode_q != MODE_BLINK) begin
                    ph_d = 1'b1;
                end
            end else if (mode_q == MODE_BLINK) begin
                if (w_blink_en) begin
                    ph_d = ~ph_q;
                end
                cur_d = ph_q ? level_q : '0;
            end else if (w_step_en) begin
                if (mode_q == MODE_BREATHE) begin
                    if (level_q == '0) begin
                        cur_d = w_cur_dn;
                    end else if (!down_q) begin
                        // Reaching (or sitting above) the peak clamps and turns around.
                        if (w_cur_up >= {1'b0, level_q}) begin
                            cur_d  = level_q;
                            down_d = 1'b1;
                        end else begin
                            cur_d = w_cur_up[PWM_BITS-1:0];
                        end
                    end else begin
                        cur_d = w_cur_dn;
                        if (w_cur_dn == '0) begin
                            down_d = 1'b0;
                        end
                    end
                end else if (cur_q < w_target) begin
                    cur_d = w_cur_up[PWM_BITS-1:0];
                end else if (cur_q > w_target) begin
                    cur_d = w_cur_dn;
                end
            end
        end

        always_comb begin
            fad_d = 1'b0;
            if (mode_d == MODE_BREATHE) begin
                fad_d = (level_d != '0);
            end else if (mode_d != MODE_BLINK) begin
                fad_d = (cur_d != w_target_d);
            end
        end

        assign duty_d = w_period_end ? cur_q : duty_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mode_q  <= MODE_OFF;
                level_q <= '0;
                cur_q   <= '0;
                duty_q  <= '0;
                down_q  <= 1'b0;
                ph_q    <= 1'b0;
            end else begin
                mode_q  <= mode_d;
                level_q <= level_d;
                cur_q   <= cur_d;
                duty_q  <= duty_d;
                down_q  <= down_d;
                ph_q    <= ph_d;
            end
        end

        // Full-scale duty must stay lit through the pwm_cnt == max slot.
        assign w_lit[gi]      = (duty_q == LEVEL_MAX) || (pwm_cnt_q < duty_q);
        assign w_fading_d[gi] = fad_d;
    end

endmodule

`default_nettype wire

// File: tb/tb_rgb_pwm_fader.sv
// ============================================================================
// Module   : tb_rgb_pwm_fader
// Brief    : Self-checking bench for rgb_pwm_fader against a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgb_pwm_fader;

    localparam int CHANNELS      = 3;
    localparam int PWM_BITS      = 4;
    localparam int PRESCALE      = 1;
    localparam int STEP_PERIODS  = 1;
    localparam int BLINK_PERIODS = 2;
    localparam int CH_BITS       = 2;
    localparam int ACTIVE_LOW    = 1;
    localparam int PERIOD        = 1 << PWM_BITS;
    localparam int MAXV          = PERIOD - 1;

    logic                clk;
    logic                rst;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_BITS-1:0]  cfg_chan;
    logic [1:0]          cfg_mode;
    logic [PWM_BITS-1:0] cfg_level;
    logic [CHANNELS-1:0] led;
    logic [CHANNELS-1:0] fading;

    rgb_pwm_fader #(
        .CHANNELS(CHANNELS), .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE),
        .STEP_PERIODS(STEP_PERIODS), .BLINK_PERIODS(BLINK_PERIODS),
        .CH_BITS(CH_BITS), .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_level(cfg_level),
        .led(led), .fading(fading)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference state: edges since reset release plus per-channel registers.
    int k;
    int m_ready;
    int m_mode  [CHANNELS];
    int m_level [CHANNELS];
    int m_cur   [CHANNELS];
    int m_down  [CHANNELS];
    int m_ph    [CHANNELS];
    int m_duty  [CHANNELS];
    int m_led   [CHANNELS];
    int m_fad   [CHANNELS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k       = 0;
        m_ready = 0;
        for (int c = 0; c < CHANNELS; c++) begin
            m_mode[c] = 0; m_level[c] = 0; m_cur[c] = 0; m_down[c] = 0;
            m_ph[c] = 0;   m_duty[c] = 0;  m_led[c] = ACTIVE_LOW; m_fad[c] = 0;
        end
    endtask

    // One clock: predict next state, take the edge, commit, compare at +1.
    task automatic cycle();
        int  pwm, q, tgt, nm, nl, nc, nd, np;
        bit  acc, pe, stp, blk;
        logic [CHANNELS-1:0] e_led, e_fad;
        int  n_mode[CHANNELS], n_level[CHANNELS], n_cur[CHANNELS], n_down[CHANNELS];
        int  n_ph[CHANNELS], n_duty[CHANNELS], n_led[CHANNELS], n_fad[CHANNELS];
        acc = cfg_valid && (m_ready == 1);
        pwm = (k / PRESCALE) % PERIOD;
        pe  = ((k % PRESCALE) == PRESCALE - 1) && (pwm == MAXV);
        q   = (k + 1) / (PERIOD * PRESCALE);
        stp = pe && (q % STEP_PERIODS == 0);
        blk = pe && (q % BLINK_PERIODS == 0);
        for (int c = 0; c < CHANNELS; c++) begin
            nm = m_mode[c]; nl = m_level[c]; nc = m_cur[c]; nd = m_down[c]; np = m_ph[c];
            if (acc && int'(cfg_chan) == c) begin
                nm = int'(cfg_mode); nl = int'(cfg_level);
                if (nm == 3 && m_mode[c] != 3) nd = 0;
                if (nm == 2 && m_mode[c] != 2) np = 1;
            end else if (m_mode[c] == 2) begin
                if (blk) np = 1 - m_ph[c];
                nc = (m_ph[c] == 1) ? m_level[c] : 0;
            end else if (stp) begin
                if (m_mode[c] == 3) begin
                    if (m_level[c] == 0) begin
                        nc = (m_cur[c] > 0) ? m_cur[c] - 1 : 0;
                    end else if (m_down[c] == 0) begin
                        if (m_cur[c] + 1 >= m_level[c]) begin nc = m_level[c]; nd = 1; end
                        else nc = m_cur[c] + 1;
                    end else begin
                        nc = (m_cur[c] > 0) ? m_cur[c] - 1 : 0;
                        if (nc == 0) nd = 0;
                    end
                end else begin
                    tgt = (m_mode[c] == 1) ? m_level[c] : 0;
                    if (m_cur[c] < tgt) nc = m_cur[c] + 1;
                    else if (m_cur[c] > tgt) nc = m_cur[c] - 1;
                end
            end
            n_mode[c] = nm; n_level[c] = nl; n_cur[c] = nc; n_down[c] = nd; n_ph[c] = np;
            n_duty[c] = pe ? m_cur[c] : m_duty[c];
            n_led[c]  = ((m_duty[c] == MAXV || pwm < m_duty[c]) ? 1 : 0) ^ ACTIVE_LOW;
            if (nm == 3)      n_fad[c] = (nl != 0) ? 1 : 0;
            else if (nm == 2) n_fad[c] = 0;
            else              n_fad[c] = (nc != ((nm == 1) ? nl : 0)) ? 1 : 0;
        end
        @(posedge clk);
        m_mode = n_mode; m_level = n_level; m_cur = n_cur; m_down = n_down;
        m_ph = n_ph; m_duty = n_duty; m_led = n_led; m_fad = n_fad;
        m_ready = acc ? 0 : 1;
        k++;
        #1;
        for (int c = 0; c < CHANNELS; c++) begin
            e_led[c] = m_led[c][0];
            e_fad[c] = m_fad[c][0];
        end
        chk("led", 32'(led), 32'(e_led));
        chk("fading", 32'(fading), 32'(e_fad));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic write(input int ch, input int mode, input int lvl, input bit hold);
        bit taken;
        cfg_valid = 1'b1;
        cfg_chan  = CH_BITS'(ch);
        cfg_mode  = 2'(mode);
        cfg_level = PWM_BITS'(lvl);
        for (int i = 0; i < 4; i++) begin
            taken = (m_ready == 1);
            cycle();
            if (taken) break;
        end
        if (!hold) cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("rst_led", 32'(led), 32'(3'b111));
            chk("rst_fading", 32'(fading), 32'(3'b000));
            chk("rst_ready", 32'(cfg_ready), 32'(1'b0));
        end
        rst = 1'b1;
    endtask

    task automatic count_low(input int ch, output int n);
        n = 0;
        for (int i = 0; i < PERIOD; i++) begin
            cycle();
            if (led[ch] == 1'b0) n++;
        end
    endtask

    int n_low;

    initial begin
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_mode  = '0;
        cfg_level = '0;
        rst       = 1'b1;
        #1;
        do_reset();
        cycle();

        // Static fade to full scale
        write(0, 1, 15, 1'b0);
        idle(17 * PERIOD);
        count_low(0, n_low);
        chk("ch0_full_low_count", 32'(n_low), 32'd16);
        chk("ch0_full_fading", 32'(fading[0]), 32'd0);

        // Static quarter duty
        write(1, 1, 4, 1'b0);
        idle(5 * PERIOD);
        count_low(1, n_low);
        chk("ch1_quarter_low_count", 32'(n_low), 32'd4);

        // Breathe then collapse to zero
        write(2, 3, 3, 1'b0);
        idle(10 * PERIOD);
        chk("ch2_breathe_fading", 32'(fading[2]), 32'd1);
        write(2, 3, 0, 1'b0);
        idle(6 * PERIOD);
        chk("ch2_zero_fading", 32'(fading[2]), 32'd0);
        count_low(2, n_low);
        chk("ch2_zero_low_count", 32'(n_low), 32'd0);

        // Blink
        write(0, 2, 8, 1'b0);
        idle(8 * PERIOD);
        chk("ch0_blink_fading", 32'(fading[0]), 32'd0);

        // Back-to-back writes, second to a non-existent channel
        write(0, 1, 5, 1'b1);
        write(3, 3, 9, 1'b0);
        idle(3 * PERIOD + 5);

        // Asynchronous reset mid-fade
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_led", 32'(led), 32'(3'b111));
        chk("async_rst_ready", 32'(cfg_ready), 32'd0);
        do_reset();
        cycle();

        // Randomized configuration traffic
        for (int it = 0; it < 80; it++) begin
            write(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, MAXV)), ($urandom_range(0, 3) == 0));
            idle(int'($urandom_range(0, 60)));
        end
        cfg_valid = 1'b0;
        idle(4 * PERIOD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
Parametrised multi-channel LED driver and successor to the fixed 3-bit-tap RGB blinker/dimmer. Each channel has a true N-bit PWM duty, a mode (off, static, blink, breathe) and a linear fade engine. Configuration arrives over a valid/ready write port from a host or sequencer. Outputs drive board LED pins directly, with selectable polarity.

Parameters:
CHANNELS, 3, number of LED channels
PWM_BITS, 8, duty/level width; PWM period = 2^PWM_BITS ticks
PRESCALE, 16, clk cycles per PWM tick (>=1)
STEP_PERIODS, 4, PWM periods per fade/breathe step (>=1)
BLINK_PERIODS, 64, PWM periods per blink half-cycle (>=1)
CH_BITS, 2, width of cfg_chan
ACTIVE_LOW, 1, 1 = LED lit when pin low

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cfg_valid  in  1  config write request
cfg_ready  out  1  block can accept a write
cfg_chan  in  CH_BITS  target channel
cfg_mode  in  2  0 OFF, 1 STATIC, 2 BLINK, 3 BREATHE
cfg_level  in  PWM_BITS  target/peak level
led  out  CHANNELS  LED pins (polarity per ACTIVE_LOW)
fading  out  CHANNELS  channel level currently moving

Behaviour:
- Reset (rst low, async): prescaler, pwm_cnt, step/blink counters = 0; per channel mode=OFF, level=0, cur=0, duty_q=0, dir=up, blink_ph=0; cfg_ready=0; fading=0; led = all inactive (all 1s when ACTIVE_LOW). cfg_ready rises on the first clk edge after rst deasserts.
- Timebase: tick every PRESCALE clks; pwm_cnt increments per tick, wraps 2^PWM_BITS-1 -> 0; period_end = tick with wrap. step_en pulses every STEP_PERIODS period_ends; blink_en every BLINK_PERIODS period_ends.
- Handshake: write accepted when cfg_valid && cfg_ready; cfg_ready = 0 the following cycle, 1 again the cycle after (max 1 write per 2 clks). Host holds cfg_* stable until accepted. cfg_chan >= CHANNELS: accepted, ignored.
- On accept: mode, level updated next edge; entering BREATHE sets dir=up; entering BLINK sets blink_ph=1 (lit phase). cur is not reset.
- Per channel on step_en:
  OFF: target 0; STATIC: target level; cur moves 1 toward target, holds when equal.
  BREATHE: dir up: cur+1; at cur>=level set dir=down (clamp cur to level if above). dir down: cur-1; at cur==0 set dir=up. level=0 -> cur steps down to 0 and holds.
  BLINK: cur unaffected by step_en; on blink_en blink_ph toggles; cur = level when blink_ph=1 else 0 (immediate, no fade).
- Write and step_en same cycle, same channel: write applied, cur not stepped that cycle.
- Output: duty_q <= cur at every period_end only (glitch-free). lit = (duty_q == 2^PWM_BITS-1) || (pwm_cnt < duty_q); led registered, one-clk latency from pwm_cnt; led = lit XOR ACTIVE_LOW. duty 0 = never lit, max = always lit.
- fading[i]: OFF/STATIC -> cur != target; BREATHE -> level != 0; BLINK -> 0. Registered.
- No wrap in arithmetic: cur saturates in [0, 2^PWM_BITS-1].
- Reset mid-fade: all state returns to reset values immediately, LEDs dark.

Test Plan:
(Bench params: CHANNELS=3, PWM_BITS=4, PRESCALE=1, STEP_PERIODS=1, BLINK_PERIODS=2, ACTIVE_LOW=1; period = 16 clks)
1. Assert rst low 5 clks, release -> led=3'b111, fading=0, cfg_ready=0 during reset, 1 on first edge after release.
2. Write ch0 STATIC level 15 -> fading[0]=1, cur 0->15 in 15 periods, then led[0]=0 every clk, fading[0]=0.
3. Write ch1 STATIC 4, wait 5 periods -> led[1] low exactly 4 of 16 clks per period, low on pwm_cnt 0..3 (+1 clk latency).
4. Write ch2 BREATHE 3 -> duty_q per period 0,1,2,3,2,1,0,1,...; fading[2]=1 throughout; then write level 0 -> ramps to 0, fading[2]=0.
5. Write ch0 BLINK 8 -> duty_q 8 for 2 periods, 0 for 2 periods, repeating; fading[0]=0.
6. Hold cfg_valid for 2 back-to-back writes (ch0, then chan=3) -> second accepted 2 clks after first, chan 3 write has no effect; assert rst mid-fade -> led=3'b111 asynchronously, before next clk.
